// File: rtl/pe_pkg.sv
// Shared widths, bit positions and encodings for the processing element.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pe_pkg;

  // Word widths
  localparam int unsigned DW = 36;  // data word: valid + tag + payload
  localparam int unsigned CW = 33;  // configuration word: valid + payload
  localparam int unsigned PW = 32;  // payload

  // Data word fields
  localparam int unsigned VLD_BIT = 35;
  localparam int unsigned TAG_HI  = 34;
  localparam int unsigned TAG_LO  = 32;

  // Configuration word valid bit
  localparam int unsigned CFG_VLD_BIT = 32;

  // Instruction fields
  localparam int unsigned I_TAG_HI = 24;
  localparam int unsigned I_TAG_LO = 22;
  localparam int unsigned I_OE     = 21;
  localparam int unsigned I_CNT_HI = 20;
  localparam int unsigned I_CNT_LO = 16;
  localparam int unsigned I_OP_HI  = 12;
  localparam int unsigned I_OP_LO  = 9;
  localparam int unsigned I_SRC_HI = 8;
  localparam int unsigned I_SRC_LO = 7;

  // Opcodes; 13..15 behave as PASS
  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_MUL  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_LT   = 4'd9,
    OP_EQ   = 4'd10,
    OP_MAX  = 4'd11,
    OP_MIN  = 4'd12
  } opcode_e;

  // Operand sources
  typedef enum logic [1:0] {
    SRC_IN0_IN1   = 2'b00,
    SRC_IN0_CONST = 2'b01,
    SRC_IN0_IN2   = 2'b10,
    SRC_CONST_IN0 = 2'b11
  } src_e;

endpackage

// File: rtl/pe_fifo2.sv
// 2-entry synchronous FIFO; ports: clk/rst_n, i_clr (sync flush), i_push/i_dat, i_pop/o_dat, o_full/o_empty.
// Latency: a pushed word is visible at o_dat the cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty; o_full is pure registered state.
module pe_fifo2
  import pe_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_dat,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [2];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dat   = r_mem[r_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_clr) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wp] <= i_dat;
  end

endmodule

// File: rtl/pe_top.sv
// Processing element: three queued inputs, configurable 32-bit ALU, one registered output word.
// Ports: clk, reset (async low), PE_Inport0..2 data in, PE_Bus_Port0 bus ctrl, Post_PE_Bp0..7 downstream ready,
//        PE_Configure_Inport config, PE_Outport0 result, Pre_PE_Bp0..2 input ready.
// Latency: word enqueued at edge k produces its result at edge k+1; 1 result/cycle.
// Backpressure: Pre_PE_Bp = queue not full; output holds while any Post_PE_Bp is low.
module pe_top
  import pe_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] PE_Inport0,
  input  logic [DW-1:0] PE_Inport1,
  input  logic [DW-1:0] PE_Inport2,
  input  logic [3:0]    PE_Bus_Port0,
  input  logic          Post_PE_Bp0,
  input  logic          Post_PE_Bp1,
  input  logic          Post_PE_Bp2,
  input  logic          Post_PE_Bp3,
  input  logic          Post_PE_Bp4,
  input  logic          Post_PE_Bp5,
  input  logic          Post_PE_Bp6,
  input  logic          Post_PE_Bp7,
  input  logic [CW-1:0] PE_Configure_Inport,
  output logic [DW-1:0] PE_Outport0,
  output logic          Pre_PE_Bp0,
  output logic          Pre_PE_Bp1,
  output logic          Pre_PE_Bp2
);

  // Configuration state
  logic          r_loaded;
  logic [PW-1:0] r_instr;
  logic [PW-1:0] r_const;
  logic [4:0]    r_count;
  logic [DW-1:0] r_out;

  // FIFO interface
  logic [DW-1:0] w_head0, w_head1, w_head2;
  logic          w_full0, w_full1, w_full2;
  logic          w_empty0, w_empty1, w_empty2;
  logic          w_push0, w_push1, w_push2;
  logic          w_pop1, w_pop2;

  // Control
  logic          w_clr;
  logic [1:0]    w_src;
  logic [3:0]    w_op;
  logic [4:0]    w_cnt_n;
  logic          w_need1, w_need2;
  logic          w_heads_ok;
  logic          w_exhausted;
  logic          w_post_all;
  logic          w_consume;
  logic          w_fire;
  logic [PW-1:0] w_a, w_b, w_res;
  logic          w_unused;

  assign w_clr   = PE_Bus_Port0[0];
  assign w_src   = r_instr[I_SRC_HI:I_SRC_LO];
  assign w_op    = r_instr[I_OP_HI:I_OP_LO];
  assign w_cnt_n = r_instr[I_CNT_HI:I_CNT_LO];

  // A port is ready purely on registered occupancy, never on this cycle's pop.
  assign Pre_PE_Bp0 = ~w_full0;
  assign Pre_PE_Bp1 = ~w_full1;
  assign Pre_PE_Bp2 = ~w_full2;

  assign w_push0 = PE_Inport0[VLD_BIT] & ~w_full0;
  assign w_push1 = PE_Inport1[VLD_BIT] & ~w_full1;
  assign w_push2 = PE_Inport2[VLD_BIT] & ~w_full2;

  // in0 is always an operand; in1/in2 only for their source selections.
  assign w_need1    = (w_src == SRC_IN0_IN1);
  assign w_need2    = (w_src == SRC_IN0_IN2);
  assign w_heads_ok = ~w_empty0 & (~w_need1 | ~w_empty1) & (~w_need2 | ~w_empty2);
  assign w_exhausted = (w_cnt_n != 5'd0) && (r_count == w_cnt_n);

  assign w_post_all = &{Post_PE_Bp0, Post_PE_Bp1, Post_PE_Bp2, Post_PE_Bp3,
                        Post_PE_Bp4, Post_PE_Bp5, Post_PE_Bp6, Post_PE_Bp7};
  assign w_consume  = r_out[VLD_BIT] & w_post_all;
  assign w_fire     = r_loaded & r_instr[I_OE] & ~w_exhausted & w_heads_ok
                    & (~r_out[VLD_BIT] | w_consume) & ~w_clr;

  assign w_pop1 = w_fire & w_need1;
  assign w_pop2 = w_fire & w_need2;

  pe_fifo2 u_fifo0 (
    .clk(clk), .rst_n(reset), .i_clr(w_clr), .i_push(w_push0), .i_dat(PE_Inport0),
    .i_pop(w_fire), .o_dat(w_head0), .o_full(w_full0), .o_empty(w_empty0)
  );

  pe_fifo2 u_fifo1 (
    .clk(clk), .rst_n(reset), .i_clr(w_clr), .i_push(w_push1), .i_dat(PE_Inport1),
    .i_pop(w_pop1), .o_dat(w_head1), .o_full(w_full1), .o_empty(w_empty1)
  );

  pe_fifo2 u_fifo2 (
    .clk(clk), .rst_n(reset), .i_clr(w_clr), .i_push(w_push2), .i_dat(PE_Inport2),
    .i_pop(w_pop2), .o_dat(w_head2), .o_full(w_full2), .o_empty(w_empty2)
  );

  // Operand selection
  always_comb begin
    w_a = w_head0[PW-1:0];
    w_b = w_head1[PW-1:0];
    case (w_src)
      SRC_IN0_IN1:   begin w_a = w_head0[PW-1:0]; w_b = w_head1[PW-1:0]; end
      SRC_IN0_CONST: begin w_a = w_head0[PW-1:0]; w_b = r_const;         end
      SRC_IN0_IN2:   begin w_a = w_head0[PW-1:0]; w_b = w_head2[PW-1:0]; end
      default:       begin w_a = r_const;         w_b = w_head0[PW-1:0]; end
    endcase
  end

  // ALU
  always_comb begin
    w_res = w_a;
    case (w_op)
      OP_ADD:  w_res = w_a + w_b;
      OP_SUB:  w_res = w_a - w_b;
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_MUL:  w_res = w_a * w_b;
      OP_SHL:  w_res = w_a << w_b[4:0];
      OP_SHR:  w_res = w_a >> w_b[4:0];
      OP_LT:   w_res = {31'd0, (w_a < w_b)};
      OP_EQ:   w_res = {31'd0, (w_a == w_b)};
      OP_MAX:  w_res = (w_a > w_b) ? w_a : w_b;
      OP_MIN:  w_res = (w_a < w_b) ? w_a : w_b;
      default: w_res = w_a;
    endcase
  end

  // First config word after reset is the instruction, later ones overwrite the constant.
  // Soft clear deliberately leaves both alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_loaded <= 1'b0;
      r_instr  <= '0;
      r_const  <= '0;
    end else if (PE_Configure_Inport[CFG_VLD_BIT]) begin
      if (!r_loaded) begin
        r_instr  <= PE_Configure_Inport[PW-1:0];
        r_loaded <= 1'b1;
      end else begin
        r_const  <= PE_Configure_Inport[PW-1:0];
      end
    end
  end

  // Output register and result counter; on consumption only the valid bit drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out   <= '0;
      r_count <= '0;
    end else if (w_clr) begin
      r_out   <= '0;
      r_count <= '0;
    end else if (w_fire) begin
      r_out   <= {1'b1, r_instr[I_TAG_HI:I_TAG_LO], w_res};
      r_count <= r_count + 5'd1;
    end else if (w_consume) begin
      r_out[VLD_BIT] <= 1'b0;
    end
  end

  assign PE_Outport0 = r_out;

  // Reserved/ignored fields, gathered so they are visibly intentional.
  assign w_unused = ^{PE_Bus_Port0[3:1],
                      PE_Inport0[TAG_HI:TAG_LO], PE_Inport1[TAG_HI:TAG_LO], PE_Inport2[TAG_HI:TAG_LO],
                      w_head0[DW-1:PW], w_head1[DW-1:PW], w_head2[DW-1:PW],
                      r_instr[31:25], r_instr[15:13], r_instr[6:0]};

endmodule

// File: tb/tb_pe_top.sv
module tb_pe_top;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] in0, in1, in2;
  logic [3:0]  bus;
  logic [7:0]  post;
  logic [32:0] cfg;
  logic [35:0] out;
  logic        bp0, bp1, bp2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_top dut (
    .clk(clk), .reset(reset),
    .PE_Inport0(in0), .PE_Inport1(in1), .PE_Inport2(in2),
    .PE_Bus_Port0(bus),
    .Post_PE_Bp0(post[0]), .Post_PE_Bp1(post[1]), .Post_PE_Bp2(post[2]), .Post_PE_Bp3(post[3]),
    .Post_PE_Bp4(post[4]), .Post_PE_Bp5(post[5]), .Post_PE_Bp6(post[6]), .Post_PE_Bp7(post[7]),
    .PE_Configure_Inport(cfg),
    .PE_Outport0(out),
    .Pre_PE_Bp0(bp0), .Pre_PE_Bp1(bp1), .Pre_PE_Bp2(bp2)
  );

  // ---------------- reference model ----------------
  logic [31:0] mq0[$], mq1[$], mq2[$];
  bit          m_loaded;
  logic [31:0] m_instr;
  logic [31:0] m_const;
  int          m_cnt;
  logic [35:0] m_out;

  function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
    longint unsigned x, y;
    x = a; y = b;
    case (op)
      1:  return 32'(x + y);
      2:  return 32'(x - y);
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return 32'(x * y);
      7:  return 32'(x << (y % 32));
      8:  return 32'(x >> (y % 32));
      9:  return (x < y) ? 32'd1 : 32'd0;
      10: return (x == y) ? 32'd1 : 32'd0;
      11: return (x > y) ? a : b;
      12: return (x < y) ? a : b;
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] mk_instr(logic [2:0] tag, bit oe, int n, int op, int src);
    logic [31:0] w;
    w = '0;
    w[24:22] = tag;
    w[21]    = oe;
    w[20:16] = 5'(n);
    w[12:9]  = 4'(op);
    w[8:7]   = 2'(src);
    return w;
  endfunction

  task automatic chk(string tag, logic [35:0] obs, logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq0.delete(); mq1.delete(); mq2.delete();
    m_loaded = 0; m_instr = '0; m_const = '0; m_cnt = 0; m_out = '0;
  endtask

  task automatic idle_inputs();
    in0 = '0; in1 = '0; in2 = '0; cfg = '0; bus = '0;
  endtask

  // One clock: predict from pre-edge state and inputs, then compare after the edge.
  task automatic tick(string tag = "cyc");
    bit clr, r0, r1, r2, need1, need2, heads, consume, fire;
    int src, op, n;
    logic [31:0] a, b, res;
    logic [35:0] s0, s1, s2;
    logic [32:0] scfg;
    s0 = in0; s1 = in1; s2 = in2; scfg = cfg;
    clr = bus[0];
    r0 = mq0.size() < 2; r1 = mq1.size() < 2; r2 = mq2.size() < 2;
    src = int'(m_instr[8:7]); op = int'(m_instr[12:9]); n = int'(m_instr[20:16]);
    need1 = (src == 0); need2 = (src == 2);
    heads = mq0.size() > 0 && (!need1 || mq1.size() > 0) && (!need2 || mq2.size() > 0);
    consume = m_out[35] && (post == 8'hFF);
    fire = !clr && m_loaded && m_instr[21] && !(n != 0 && m_cnt >= n) && heads && (!m_out[35] || consume);
    res = '0;
    if (fire) begin
      case (src)
        0:       begin a = mq0[0];  b = mq1[0];  end
        1:       begin a = mq0[0];  b = m_const; end
        2:       begin a = mq0[0];  b = mq2[0];  end
        default: begin a = m_const; b = mq0[0];  end
      endcase
      res = ref_alu(op, a, b);
    end
    @(posedge clk);
    #1;
    if (clr) begin
      m_out = '0; m_cnt = 0;
      mq0.delete(); mq1.delete(); mq2.delete();
    end else begin
      if (fire) begin
        m_out = {1'b1, m_instr[24:22], res};
        m_cnt++;
        void'(mq0.pop_front());
        if (need1) void'(mq1.pop_front());
        if (need2) void'(mq2.pop_front());
      end else if (consume) begin
        m_out[35] = 1'b0;
      end
      if (s0[35] && r0) mq0.push_back(s0[31:0]);
      if (s1[35] && r1) mq1.push_back(s1[31:0]);
      if (s2[35] && r2) mq2.push_back(s2[31:0]);
    end
    if (scfg[32]) begin
      if (!m_loaded) begin m_instr = scfg[31:0]; m_loaded = 1; end
      else m_const = scfg[31:0];
    end
    chk({tag, "_out"}, out, m_out);
    chk({tag, "_bp"}, {33'd0, bp2, bp1, bp0},
        {33'd0, mq2.size() < 2, mq1.size() < 2, mq0.size() < 2});
  endtask

  task automatic send_cfg(logic [31:0] w);
    cfg = {1'b1, w};
    tick("cfg");
    cfg = '0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    chk("rst_out", out, 36'h0);
    chk("rst_bp", {33'd0, bp2, bp1, bp0}, 36'h7);
  endtask

  initial begin
    int nvalid;
    logic [31:0] ins;
    reset = 1'b0;
    post  = 8'hFF;
    idle_inputs();
    model_reset();
    #12;
    reset = 1'b1;
    chk("init_out", out, 36'h0);
    chk("init_bp", {33'd0, bp2, bp1, bp0}, 36'h7);

    // Inputs before configuration queue up, third is dropped, nothing is produced.
    in0 = {1'b1, 3'd0, 32'hA}; tick("pre");
    in0 = {1'b1, 3'd0, 32'hB}; tick("pre");
    in0 = {1'b1, 3'd0, 32'hC}; tick("pre");
    in0 = '0; tick("pre");
    chk("pre_noout", {35'd0, out[35]}, 36'd0);
    chk("pre_bp0", {35'd0, bp0}, 36'd0);
    bus = 4'b0001; tick("sclr");
    bus = 4'b0000;
    chk("sclr_bp0", {35'd0, bp0}, 36'd1);

    // MUL by constant
    send_cfg(mk_instr(3'b101, 1, 5, 6, 1));
    send_cfg(32'd0);
    send_cfg(32'd5);
    in0 = {1'b1, 3'd0, 32'd3}; tick("mul");
    in0 = '0; tick("mul");
    chk("mul15", out, {1'b1, 3'b101, 32'd15});
    // Constant write on the firing edge: the old constant (5) is used.
    in0 = {1'b1, 3'd0, 32'd4}; tick("mul");
    in0 = '0; cfg = {1'b1, 32'd7}; tick("mul");
    cfg = '0;
    chk("mul_oldconst", out, {1'b1, 3'b101, 32'd20});
    in0 = {1'b1, 3'd0, 32'd2}; tick("mul");
    in0 = '0; tick("mul");
    chk("mul_newconst", out, {1'b1, 3'b101, 32'd14});

    // Swapped compare: const < in0
    reset_pulse();
    send_cfg(mk_instr(3'b010, 1, 3, 9, 3));
    send_cfg(32'd2);
    in0 = {1'b1, 3'd0, 32'd3}; tick("lt");
    in0 = {1'b1, 3'd0, 32'd1}; tick("lt");
    chk("lt_true", out, {1'b1, 3'b010, 32'd1});
    in0 = '0; tick("lt");
    chk("lt_false", out, {1'b1, 3'b010, 32'd0});

    // Backpressure: downstream port 0 stalls
    reset_pulse();
    send_cfg(mk_instr(3'b001, 1, 0, 1, 1));
    send_cfg(32'd100);
    post = 8'hFE;
    in0 = {1'b1, 3'd0, 32'd1}; tick("bp");
    in0 = {1'b1, 3'd0, 32'd2}; tick("bp");
    chk("bp_hold1", out, {1'b1, 3'b001, 32'd101});
    in0 = {1'b1, 3'd0, 32'd3}; tick("bp");
    in0 = {1'b1, 3'd0, 32'd4}; tick("bp");
    chk("bp_hold2", out, {1'b1, 3'b001, 32'd101});
    chk("bp_full", {35'd0, bp0}, 36'd0);
    in0 = '0; post = 8'hFF; tick("bp");
    chk("bp_drain2", out, {1'b1, 3'b001, 32'd102});
    tick("bp");
    chk("bp_drain3", out, {1'b1, 3'b001, 32'd103});
    tick("bp");
    chk("bp_done", {35'd0, out[35]}, 36'd0);

    // Count exhaustion
    reset_pulse();
    send_cfg(mk_instr(3'b110, 1, 3, 0, 1));
    nvalid = 0;
    for (int i = 0; i < 9; i++) begin
      in0 = (i < 5) ? {1'b1, 3'd0, 32'(i + 40)} : 36'd0;
      tick("cnt");
      if (out[35]) nvalid++;
    end
    chk("cnt_results", 36'(nvalid), 36'd3);
    chk("cnt_bp0", {35'd0, bp0}, 36'd0);
    bus = 4'b0001; tick("cnt_clr");
    bus = 4'b0000;
    in0 = {1'b1, 3'd0, 32'd99}; tick("cnt");
    in0 = '0; tick("cnt");
    chk("cnt_after_clr", out, {1'b1, 3'b110, 32'd99});

    // Two-input ADD, in1 arrives two cycles after in0
    reset_pulse();
    send_cfg(mk_instr(3'b011, 1, 0, 1, 0));
    in0 = {1'b1, 3'd0, 32'd7}; tick("add2");
    in0 = '0; tick("add2");
    chk("add2_wait", {35'd0, out[35]}, 36'd0);
    in1 = {1'b1, 3'd0, 32'd8}; tick("add2");
    in1 = '0;
    chk("add2_wait2", {35'd0, out[35]}, 36'd0);
    tick("add2");
    chk("add2_sum", out, {1'b1, 3'b011, 32'd15});
    tick("add2");
    chk("add2_once", {35'd0, out[35]}, 36'd0);

    // Randomized segments checked every cycle against the model
    for (int seg = 0; seg < 6; seg++) begin
      reset_pulse();
      ins = $urandom;
      ins[21] = ($urandom_range(0, 7) != 0);
      ins[20:16] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      send_cfg(ins);
      send_cfg($urandom_range(0, 40));
      for (int c = 0; c < 200; c++) begin
        in0 = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 40))};
        in1 = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 40))};
        in2 = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom)};
        post = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
        bus = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 39) == 0)};
        cfg = ($urandom_range(0, 19) == 0) ? {1'b1, 32'($urandom_range(0, 40))} : 33'd0;
        tick("rnd");
      end
      idle_inputs();
      post = 8'hFF;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
